// File: rtl/seq_digit_adder.sv
// ---------------------------------------------------------------------------
// seq_digit_adder
//
// Adds two WIDTH-bit operands plus a carry-in, one DIGIT-bit digit per clock,
// starting with the least-significant digit. A single DIGIT-wide adder is
// reused on every RUN cycle. The carry between digits is kept in a register.
//
// Optional feature: define SEQ_DIGIT_ADDER_SUB_EN to add the 'sub' input.
// When sub=1, the block computes A + ~B + 1 and ignores cin. In that mode
// cout=1 means no borrow. When the macro is undefined, 'sub' does not exist
// and the block only adds.
//
// Parameters
//   WIDTH  operand/result width in bits. Must be a multiple of DIGIT.
//   DIGIT  bits added per clock; N = WIDTH/DIGIT digits per operation
//
// Ports
//   clk    rising-edge clock
//   rst    asynchronous, active-high reset
//   start  begin an addition; sampled only while idle
//   a, b   operands, captured when start is accepted
//   cin    carry-in into digit 0, captured with the operands
//   sub    (SEQ_DIGIT_ADDER_SUB_EN only) subtract B instead of adding it
//   sum    registered result; holds its value until the next start
//   cout   registered carry-out of the top digit; holds like sum
//   busy   high while the operation is running and during the done cycle
//   done   one-cycle pulse; sum/cout are valid while it is high
//
// Timing: the start edge, then N RUN edges, then one DONE cycle. An observer
// sampling on rising edges sees done at edge N+1 after the start edge.
// ---------------------------------------------------------------------------
module seq_digit_adder #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SEQ_DIGIT_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy,
  output logic             done
);

  localparam int N  = WIDTH / DIGIT;
  // Keep the counter at least one bit wide so that N = 1 still elaborates.
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST_DIGIT = CW'(N - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic [DIGIT-1:0] a_digit;
  logic [DIGIT-1:0] b_digit;
  logic [DIGIT:0]   digit_sum;
  logic             last_digit;

  // The single shared digit adder. Its extra top bit is the carry out of the digit.
  assign a_digit    = a_q[cnt*DIGIT +: DIGIT];
  assign b_digit    = b_q[cnt*DIGIT +: DIGIT];
  assign digit_sum  = {1'b0, a_digit} + {1'b0, b_digit} + {{DIGIT{1'b0}}, carry};
  assign last_digit = (cnt == LAST_DIGIT);

  // State register
  // NOTE: clocked state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic
  // NOTE: defaulting every combinational output first prevents latch inference.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last_digit) state_next = DONE;
      DONE:    state_next = IDLE;   // start is deliberately not looked at here
      default: state_next = IDLE;
    endcase
  end

  // Output logic (Moore: decoded from state only)
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      RUN:     busy = 1'b1;
      DONE:    begin busy = 1'b1; done = 1'b1; end
      default: ;
    endcase
  end

  // Datapath: operand capture, digit-serial accumulation, carry-out
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_q <= a;
`ifdef SEQ_DIGIT_ADDER_SUB_EN
            // Subtraction is A + ~B + 1. The +1 enters through the carry register.
            b_q   <= sub ? ~b : b;
            carry <= sub ? 1'b1 : cin;
`else
            b_q   <= b;
            carry <= cin;
`endif
            cnt <= '0;
            // Clear digits that have not been written yet, so no stale result shows.
            sum <= '0;
          end
        end
        RUN: begin
          sum[cnt*DIGIT +: DIGIT] <= digit_sum[DIGIT-1:0];
          carry                   <= digit_sum[DIGIT];
          cnt                     <= cnt + 1'b1;
          if (last_digit) cout <= digit_sum[DIGIT];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_digit_adder.sv
// ---------------------------------------------------------------------------
// tb_seq_digit_adder
//
// Directed test of seq_digit_adder. The main instance uses WIDTH=16, DIGIT=4.
// A second instance uses WIDTH=8, DIGIT=8, the single-digit case. Inputs are
// driven on falling edges. Outputs are sampled on falling edges, between two
// rising edges.
// ---------------------------------------------------------------------------
module tb_seq_digit_adder;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] a, b;
  logic        cin;
  logic [15:0] sum;
  logic        cout, busy, done;
`ifdef SEQ_DIGIT_ADDER_SUB_EN
  logic        sub;
`endif

  logic        start8;
  logic [7:0]  a8, b8;
  logic        cin8;
  logic [7:0]  sum8;
  logic        cout8, busy8, done8;
`ifdef SEQ_DIGIT_ADDER_SUB_EN
  logic        sub8;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq_digit_adder #(.WIDTH(16), .DIGIT(4)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
`ifdef SEQ_DIGIT_ADDER_SUB_EN
    .sub(sub),
`endif
    .sum(sum), .cout(cout), .busy(busy), .done(done)
  );

  seq_digit_adder #(.WIDTH(8), .DIGIT(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
`ifdef SEQ_DIGIT_ADDER_SUB_EN
    .sub(sub8),
`endif
    .sum(sum8), .cout(cout8), .busy(busy8), .done(done8)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Runs one operation on the 16-bit instance. Call it during the clock-low phase.
  // It returns on a falling edge, one cycle after the done cycle.
  // With disturb=1, the task changes operands and pulses start while RUN is in progress.
  task automatic run_op(input string tag, input logic [15:0] op_a, input logic [15:0] op_b,
                        input logic op_cin, input logic [15:0] exp_sum, input logic exp_cout,
                        input bit disturb);
    int n;
    bit busy_ok;
    bit extra_done;
    a = op_a; b = op_b; cin = op_cin; start = 1'b1;
    @(posedge clk);                       // start edge
    n = 0;
    busy_ok = 1'b1;
    while (n < 12) begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        start = 1'b0;
        check({tag, "_sum_cleared"}, sum, 16'h0000);
      end
      if (disturb && n == 2) begin
        a = 16'hAAAA; b = 16'hFFFF; cin = 1'b0; start = 1'b1;
      end
      if (disturb && n == 3) start = 1'b0;
      if (done) break;
      if (!busy) busy_ok = 1'b0;
    end
    check({tag, "_latency"}, n, 5);
    check({tag, "_busy_run"}, busy_ok, 1'b1);
    check({tag, "_busy_done"}, busy, 1'b1);
    check({tag, "_sum"}, sum, exp_sum);
    check({tag, "_cout"}, cout, exp_cout);
    @(negedge clk);
    check({tag, "_done_pulse"}, done, 1'b0);
    check({tag, "_busy_idle"}, busy, 1'b0);
    check({tag, "_sum_hold"}, sum, exp_sum);
    if (disturb) begin
      extra_done = 1'b0;
      repeat (8) begin
        @(negedge clk);
        if (done || busy) extra_done = 1'b1;
      end
      check({tag, "_no_second_op"}, extra_done, 1'b0);
      check({tag, "_sum_after"}, sum, exp_sum);
      check({tag, "_cout_after"}, cout, exp_cout);
    end
  endtask

  initial begin
    int n;
    int ndone;
    int done_at [3];
    bit seen;

    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
`ifdef SEQ_DIGIT_ADDER_SUB_EN
    sub = 1'b0; sub8 = 1'b0;
`endif
    #1;
    check("rst_sum", sum, 16'h0000);
    check("rst_cout", cout, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);

    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    // This start comes right after reset release. A latency of 5 shows that the first edge accepted it.
    run_op("add_ffff_0001", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_op("add_1234_4321", 16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b1);
    run_op("add_8001_8002", 16'h8001, 16'h8002, 1'b0, 16'h0003, 1'b1, 1'b0);

    // Assert reset two edges into RUN. cout still holds 1 from the previous operation.
    a = 16'h00FF; b = 16'h0001; cin = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrun_rst_sum", sum, 16'h0000);
    check("midrun_rst_cout", cout, 1'b0);
    check("midrun_rst_busy", busy, 1'b0);
    check("midrun_rst_done", done, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    check("midrun_rst_no_done", seen, 1'b0);
    run_op("after_rst", 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0);

    // Hold start high: an operation should be accepted every 6 edges.
    a = 16'h0001; b = 16'h0002; cin = 1'b0; start = 1'b1;
    @(posedge clk);
    n = 0; ndone = 0;
    done_at[0] = 0; done_at[1] = 0; done_at[2] = 0;
    repeat (20) begin
      @(negedge clk);
      n++;
      if (done) begin
        if (ndone < 3) done_at[ndone] = n;
        ndone++;
        check("b2b_sum", sum, 16'h0003);
      end
    end
    start = 1'b0;
    check("b2b_count", ndone, 3);
    check("b2b_first", done_at[0], 5);
    check("b2b_second", done_at[1], 11);
    check("b2b_third", done_at[2], 17);
    repeat (10) @(negedge clk);

`ifdef SEQ_DIGIT_ADDER_SUB_EN
    sub = 1'b1;
    run_op("sub_5_7", 16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    run_op("sub_7_5", 16'h0007, 16'h0005, 1'b0, 16'h0002, 1'b1, 1'b0);
    sub = 1'b0;
`endif

    // Single-digit instance: done two edges after start.
    a8 = 8'h80; b8 = 8'h80; cin8 = 1'b0; start8 = 1'b1;
    @(posedge clk);
    n = 0;
    while (n < 8) begin
      @(negedge clk);
      n++;
      start8 = 1'b0;
      if (done8) break;
    end
    check("w8_latency", n, 2);
    check("w8_sum", sum8, 8'h00);
    check("w8_cout", cout8, 1'b1);
    @(negedge clk);
    a8 = 8'h7F; b8 = 8'h01; cin8 = 1'b1; start8 = 1'b1;
    @(posedge clk);
    n = 0;
    while (n < 8) begin
      @(negedge clk);
      n++;
      start8 = 1'b0;
      if (done8) break;
    end
    check("w8b_latency", n, 2);
    check("w8b_sum", sum8, 8'h81);
    check("w8b_cout", cout8, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_digit_adder.md
SEQ_DIGIT_ADDER -- requirements
Module: seq_digit_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 16, meaning operand/result width in bits.
REQ-002 SHALL have parameter DIGIT, default 4, meaning bits added per clock; WIDTH SHALL be an integer multiple of DIGIT; N = WIDTH/DIGIT.
REQ-003 SHALL have port clk  input  1  single clock, rising-edge active.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  input  1  request to begin an addition; sampled only in IDLE.
REQ-006 SHALL have port a  input  WIDTH  operand A.
REQ-007 SHALL have port b  input  WIDTH  operand B.
REQ-008 SHALL have port cin  input  1  carry-in into the least-significant digit.
REQ-009 SHALL have port sum  output  WIDTH  registered result.
REQ-010 SHALL have port cout  output  1  registered carry-out of the most-significant digit.
REQ-011 SHALL have port busy  output  1  high in RUN and DONE.
REQ-012 SHALL have port done  output  1  one-cycle pulse, result valid.

Function
REQ-013 SHALL implement a three-state FSM: IDLE, RUN, DONE.
REQ-014 In IDLE, start=1 at a rising edge SHALL capture a, b, cin (and sub when compiled in), clear the digit counter to 0 and enter RUN.
REQ-015 Each RUN edge SHALL add digit k of the captured A and B plus the carry register with one DIGIT-wide adder, write the DIGIT sum bits into sum[k*DIGIT +: DIGIT], update the carry register and increment k, digits processed LSB first.
REQ-016 After the edge processing digit N-1, SHALL enter DONE, drive cout from the carry register and assert done for exactly one cycle.
REQ-017 DONE SHALL return to IDLE on the next edge unconditionally; start in DONE SHALL be ignored.
REQ-018 Latency: done SHALL be high exactly N+1 rising edges after the edge that sampled start (N edges in RUN, then one edge registering DONE).
REQ-019 start and changes of a, b, cin during RUN or DONE SHALL be ignored; captured operands SHALL be used.
REQ-020 sum and cout SHALL hold their last value from DONE through IDLE until the next start is accepted.
REQ-021 sum bits of digits not yet processed SHALL be undefined-free: cleared to 0 when start is accepted.
REQ-022 Result SHALL equal (A + B + cin) mod 2^WIDTH with cout = bit WIDTH of the true sum.
REQ-023 DIGIT = WIDTH (N = 1) SHALL be supported: one RUN edge, done 2 edges after start.

Reset
REQ-024 rst=1 SHALL immediately, without a clock edge, force state IDLE, sum=0, cout=0, busy=0, done=0, carry register=0, counter=0.
REQ-025 rst asserted mid-RUN SHALL abort the operation; no done pulse SHALL be produced for it.
REQ-026 After rst deasserts, the first rising edge SHALL already honour start.

Configuration
REQ-027 With macro SEQ_DIGIT_ADDER_SUB_EN defined, SHALL add port sub  input  1  captured with start; sub=1 SHALL compute A + ~B + 1 (cin ignored), cout = 1 meaning no borrow; sub=0 behaves as addition.
REQ-028 Without SEQ_DIGIT_ADDER_SUB_EN, port sub SHALL not exist and the block SHALL perform addition only.

Verification (WIDTH=16, DIGIT=4, N=4)
REQ-029 a=0xFFFF, b=0x0001, cin=0, start pulse -> done on 5th edge after start edge, sum=0x0000, cout=1, busy high 4 cycles before done and during done.
REQ-030 a=0x1234, b=0x4321, cin=1 -> sum=0x5556, cout=0; then change a to 0xAAAA and pulse start during RUN -> result unchanged, no second operation.
REQ-031 rst pulse two edges into RUN of a=0x00FF, b=0x0001 -> sum=0, cout=0, busy=0 asynchronously; no done pulse; next start with same operands -> sum=0x0100, cout=0.
REQ-032 Back-to-back: start held high continuously -> operations accepted every 6 edges (IDLE, 4 RUN, DONE), done one cycle each.
REQ-033 With SEQ_DIGIT_ADDER_SUB_EN: a=0x0005, b=0x0007, sub=1 -> sum=0xFFFE, cout=0; a=0x0007, b=0x0005, sub=1 -> sum=0x0002, cout=1.
REQ-034 Parameter sweep WIDTH=8, DIGIT=8 -> a=0x80, b=0x80, cin=0 -> done 2 edges after start, sum=0x00, cout=1.
